uart_tx_framer: RTL
===================

// Module: uart_tx_framer
// PURPOSE
//  Parametrised UART transmit engine: builds a full serial frame from parallel data and shifts it out LSB first on tx.
//  Frame = start bit, data, optional parity, stop bit(s).
//  Data length, parity and stop-bit count are run-time selectable.
//  Has a one-deep holding buffer, so the CPU can queue the next byte while the current frame shifts.
//  Sits between the TSI/CPU write path and the tx pad, and replaces the fixed 8-bit bit9/bit10 decode-plus-shift path.
// PARAMETERS
//  DW     8   max data width; data_len selects DW-3..DW bits
//  BAUD_W 19  width of baud_div
// PORTS
//  clk      in  1      system clock
//  reset    in  1      asynchronous, active-high reset
//  baud_div in  BAUD_W clocks per bit; 0 treated as 1
//  data_len in  2      data bits = DW-3+data_len (DW=8: 00=5, 01=6, 10=7, 11=8)
//  pen      in  1      parity enable
//  ohel     in  1      1=odd parity, 0=even parity
//  stop2    in  1      1=two stop bits, 0=one
//  data     in  DW     byte to send; bits above selected length ignored
//  load     in  1      write strobe; accepted only when tx_rdy=1
//  clr_ovr  in  1      clears ovr
//  tx       out 1      serial line, idles high
//  tx_rdy   out 1      holding register empty
//  tx_busy  out 1      frame in progress (state SHIFT)
//  tx_done  out 1      1-clk pulse after final stop bit completes
//  ovr      out 1      sticky: load seen while tx_rdy=0
// BEHAVIOUR
//  Reset (async): tx=1, tx_rdy=1, tx_busy=0, tx_done=0, ovr=0; FSM=IDLE; all counters and buffers cleared.
//    Reset mid-frame aborts immediately: tx=1 in the same cycle.
//  Accept: load=1 and tx_rdy=1 at edge n -> hold<=data, tx_rdy=0 from n.
//  Overrun: load=1 and tx_rdy=0 -> data dropped, ovr<=1.
//    ovr holds until clr_ovr=1 or reset; if clr_ovr and a new overrun coincide, the overrun wins.
//  FSM IDLE->SHIFT when hold is full, at the edge after the accept.
//    At that edge: shifter<=frame; data_len/pen/ohel/stop2 latched; tx<=0 (start bit); tx_rdy<=1; bit_cnt<=0; baud_cnt<=0.
//    Config changes mid-frame take effect only on the next frame.
//  Frame bits in order: 0, d[0]..d[L-1], [parity if pen], 1, [1 if stop2].
//    Total bits N = 2+L+pen+stop2 (range 7..12 for DW=8).
//  Parity computed over the L selected bits only:
//    even -> ^d[L-1:0]
//    odd  -> ~^d[L-1:0]
//  Bit timing: each bit is held for max(baud_div,1) clocks.
//    baud_cnt counts up; at terminal count the next bit is shifted out and bit_cnt increments.
//  End of frame: when bit_cnt reaches N-1 and the terminal count hits:
//    if hold is full -> next frame starts on that edge (back-to-back; no idle gap, tx_done still pulses);
//    else -> FSM IDLE, tx=1.
//    tx_done=1 for exactly one clk on that edge.
//  tx_busy=1 exactly while FSM=SHIFT.
//  Load during SHIFT with tx_rdy=1 is legal: queued in hold, sent back-to-back.
//  Simultaneous load and hold->shifter transfer on the same edge:
//    transfer uses the old hold; the new data is accepted into hold (tx_rdy stays 0).
//  No latency other than the 1-clk hold->shift transfer; all outputs registered.
// TESTING
//  T1 DW=8, baud_div=4, len=11, pen=0, stop2=0, load 8'hA5 from idle
//     -> tx low 1 clk after accept; bits 0,1,0,1,0,0,1,0,1,1 at 4 clk each; tx_done pulse; tx_busy=0 after.
//  T2 len=11, pen=1, ohel=0, data 8'h07 -> parity bit 1; ohel=1 -> parity bit 0; frame is 11 bits (44 clk at div 4).
//  T3 len=00, pen=1, ohel=0, stop2=1, data 8'hFF -> 5 data bits 1, parity 1, two stops; N=9; bits d[7:5] never appear.
//  T4 load 8'h11 then 8'h22 while the first shifts; third load before the second starts
//     -> frames back-to-back (no idle bit), ovr=1, 3rd byte absent; clr_ovr -> ovr=0.
//  T5 assert reset mid-data-bit with baud_div=10 -> tx=1 same cycle, tx_rdy=1, ovr=0; a new load sends a clean full frame.
//  T6 baud_div=0 and baud_div=1 -> both give 1 clk per bit; change pen mid-frame -> current frame unchanged.

Source files
------------

// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   UART transmit engine. Builds a serial frame from parallel data and
//   shifts it out LSB first: start bit, DW-3+data_len data bits, optional
//   parity, one or two stop bits. A one-deep holding register lets the next
//   byte be queued while the current frame shifts; a queued byte follows the
//   current frame with no idle gap.
//
// Ports
//   clk      system clock
//   reset    asynchronous, active-high reset
//   baud_div clocks per bit (0 behaves as 1)
//   data_len data bits = DW-3+data_len
//   pen      parity enable
//   ohel     1 = odd parity, 0 = even parity
//   stop2    1 = two stop bits, 0 = one
//   data     byte to send; bits above the selected length are ignored
//   load     write strobe into the holding register
//   clr_ovr  clears ovr
//   tx       serial line, idles high
//   tx_rdy   holding register empty
//   tx_busy  frame in progress
//   tx_done  one-clock pulse when the final stop bit completes
//   ovr      sticky overrun flag (load while the holding register is full)

module uart_tx_framer #(
  parameter int DW     = 8,
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic [1:0]        data_len,
  input  logic              pen,
  input  logic              ohel,
  input  logic              stop2,
  input  logic [DW-1:0]     data,
  input  logic              load,
  input  logic              clr_ovr,
  output logic              tx,
  output logic              tx_rdy,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              ovr
);

  localparam int FW = DW + 4;
  localparam int CW = $clog2(FW + 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;

  logic [DW-1:0]     hold;
  logic [FW-1:0]     sh;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     nbits_q;
  logic [BAUD_W-1:0] baud_cnt;

  logic [BAUD_W-1:0] div_m1;
  logic [CW-1:0]     len;
  logic [CW-1:0]     ppos;
  logic [CW-1:0]     nbits;
  logic [DW-1:0]     dmask;
  logic [DW-1:0]     dsel;
  logic [FW-1:0]     frame;
  logic              par;
  logic              tick;
  logic              last;
  logic              xfer;
  logic              take;
  logic              ovr_set;

  always_comb begin
    div_m1  = (baud_div == '0) ? '0 : baud_div - 1'b1;
    // >= so a mid-bit reduction of baud_div cannot strand the counter
    tick    = (baud_cnt >= div_m1);
    last    = (bit_cnt == nbits_q - 1'b1);
    // hold -> shifter: from IDLE whenever hold is full, or at the end of a
    // frame for back-to-back transmission
    xfer    = !tx_rdy && ((state == IDLE) || (tick && last));
    // a load coinciding with the transfer refills the slot being vacated
    take    = load && (tx_rdy || xfer);
    ovr_set = load && !take;

    len   = CW'(DW - 3) + CW'(data_len);
    ppos  = len + CW'(1);
    nbits = len + CW'(2) + CW'(pen) + CW'(stop2);

    dmask = ~({DW{1'b1}} << len);
    dsel  = hold & dmask;
    par   = ohel ^ (^dsel);

    // Frame LSB first: bit0 = start (0), bits 1..L = data, everything above
    // is 1 (stop bits), except the parity slot which is cleared when needed.
    frame = (FW'(dsel) << 1) | ({FW{1'b1}} << ppos);
    if (pen && !par) begin
      frame = frame & ~(FW'(1) << ppos);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold     <= '0;
      sh       <= '1;
      bit_cnt  <= '0;
      nbits_q  <= '0;
      baud_cnt <= '0;
      tx       <= 1'b1;
      tx_rdy   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (take) begin
        hold   <= data;
        tx_rdy <= 1'b0;
      end else if (xfer) begin
        tx_rdy <= 1'b1;
      end

      if (ovr_set) begin
        ovr <= 1'b1;
      end else if (clr_ovr) begin
        ovr <= 1'b0;
      end

      // Configuration is captured entirely in sh/nbits_q at frame start,
      // so later changes only affect the next frame.
      if (xfer) begin
        state    <= SHIFT;
        tx_busy  <= 1'b1;
        tx       <= frame[0];
        sh       <= {1'b1, frame[FW-1:1]};
        nbits_q  <= nbits;
        bit_cnt  <= '0;
        baud_cnt <= '0;
        if (state == SHIFT) begin
          tx_done <= 1'b1;
        end
      end else if (state == SHIFT) begin
        if (tick) begin
          baud_cnt <= '0;
          if (last) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b1;
          end else begin
            tx      <= sh[0];
            sh      <= {1'b1, sh[FW-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

endmodule
